j_systolic_scheduler: RTL and testbench

- Command-driven sequencer for one j_systolic_array instance.
- Accepts a job descriptor, walks the weight-load phase column by column, streams input beats with MAC enables and an accumulator clear, then drains the pipeline and signals completion.
- Sits between the host/DMA command queue and the array's control ports.
- The data buses (dataflow_in, accumulation_in) bypass this block; only their handshake passes through it.

---
 rtl/j_sched_pkg.sv | 24 ++
 rtl/j_onehot_walker.sv | 34 +++
 rtl/j_systolic_scheduler.sv | 160 ++++++++++++++++
 tb/tb_j_systolic_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j_sched_pkg.sv
// Shared state encoding and elaboration helpers for the systolic-array job scheduler.
package j_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } sched_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // The pipeline empties once a beat has crossed every row and every column.
  function automatic int drain_cycles_default(input int width, input int height);
    return width + height;
  endfunction

endpackage

// File: rtl/j_onehot_walker.sv
// One-hot column walker: each advance emits a registered strobe on the current column and moves to the next.
// Strobe is valid one cycle after the advance; clear returns to column 0.
module j_onehot_walker #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_strobe,
  output logic             o_last
);

  logic [WIDTH-1:0] r_pos;
  logic [WIDTH-1:0] r_strobe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos    <= WIDTH'(1);
      r_strobe <= '0;
    end else begin
      r_strobe <= i_advance ? r_pos : '0;
      if (i_clear) begin
        r_pos <= WIDTH'(1);
      end else if (i_advance) begin
        r_pos <= {r_pos[WIDTH-2:0], r_pos[WIDTH-1]};
      end
    end
  end

  assign o_strobe = r_strobe;
  assign o_last   = r_pos[WIDTH-1];

endmodule

// File: rtl/j_systolic_scheduler.sv
// Job sequencer for one j_systolic_array: weight load, beat streaming with MAC/clear strobes, drain, done pulse.
// Outputs registered, valid one cycle after the accepting edge; SCHED_PERF_CNT_EN adds stall_count.
module j_systolic_scheduler
  import j_sched_pkg::*;
#(
  parameter int SUBARRAY_WIDTH      = 32,
  parameter int SUBARRAY_HEIGHT     = 32,
  parameter int NUM_DATAFLOW_PER_MX = 8,
  parameter int W_DATA_MUX          = clog2(NUM_DATAFLOW_PER_MX),
  parameter int W_LEN               = 16,
  parameter int DRAIN_CYCLES        = drain_cycles_default(SUBARRAY_WIDTH, SUBARRAY_HEIGHT)
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                cmd_valid,
  output logic                                                cmd_ready,
  input  logic [W_LEN-1:0]                                    cmd_len,
  input  logic [W_DATA_MUX-1:0]                               cmd_sel,
  input  logic                                                cmd_skip_wload,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  output logic [SUBARRAY_WIDTH-1:0]                           arr_update_w,
  output logic [SUBARRAY_WIDTH*SUBARRAY_HEIGHT*W_DATA_MUX-1:0] arr_dataflow_select,
  output logic [4*SUBARRAY_HEIGHT-1:0]                        arr_mac_en,
  output logic [4*SUBARRAY_HEIGHT-1:0]                        arr_clr_and_plus_one,
  input  logic [4*SUBARRAY_HEIGHT-1:0]                        arr_result_en,
  output logic                                                busy,
  output logic                                                done,
  output logic [W_LEN-1:0]                                    result_count
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                                         stall_count
`endif
);

  localparam int N_LANES = 4 * SUBARRAY_HEIGHT;
  localparam int N_PE    = SUBARRAY_WIDTH * SUBARRAY_HEIGHT;
  localparam int W_DRN   = clog2(DRAIN_CYCLES) + 1;
  localparam logic [W_DRN-1:0] DRN_LAST = W_DRN'(DRAIN_CYCLES - 1);

  sched_state_t r_state;
  sched_state_t w_next;

  logic                       r_cmd_ready;
  logic                       r_in_ready;
  logic                       r_busy;
  logic                       r_done;
  logic [W_LEN-1:0]           r_len;
  logic [W_LEN-1:0]           r_cnt;
  logic [W_LEN-1:0]           r_result_cnt;
  logic [W_DRN-1:0]           r_drn;
  logic [N_LANES-1:0]         r_mac_en;
  logic [N_LANES-1:0]         r_clr;
  logic [N_PE*W_DATA_MUX-1:0] r_dfs;

  logic                       w_accept;
  logic                       w_beat;
  logic                       w_load_beat;
  logic                       w_stream_beat;
  logic                       w_last_beat;
  logic                       w_col_last;
  logic [SUBARRAY_WIDTH-1:0]  w_update_w;

  assign w_accept      = cmd_valid && r_cmd_ready;
  assign w_beat        = in_valid && r_in_ready;
  assign w_load_beat   = w_beat && (r_state == LOAD_W);
  assign w_stream_beat = w_beat && (r_state == STREAM);
  assign w_last_beat   = (r_cnt == r_len - W_LEN'(1));

  j_onehot_walker #(
    .WIDTH(SUBARRAY_WIDTH)
  ) u_walker (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_accept),
    .i_advance(w_load_beat),
    .o_strobe (w_update_w),
    .o_last   (w_col_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (cmd_len == '0)      w_next = DONE;
          else if (cmd_skip_wload) w_next = STREAM;
          else                     w_next = LOAD_W;
        end
      end
      LOAD_W:  if (w_load_beat && w_col_last) w_next = STREAM;
      STREAM:  if (w_stream_beat && w_last_beat) w_next = DRAIN;
      DRAIN:   if (r_drn == DRN_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake/status flags are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_ready  <= 1'b1;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_drn        <= '0;
      r_result_cnt <= '0;
      r_mac_en     <= '0;
      r_clr        <= '0;
      r_dfs        <= '0;
    end else begin
      r_cmd_ready <= (w_next == IDLE);
      r_in_ready  <= (w_next == LOAD_W) || (w_next == STREAM);
      r_busy      <= (w_next == LOAD_W) || (w_next == STREAM) || (w_next == DRAIN);
      r_done      <= (w_next == DONE);
      r_mac_en    <= {N_LANES{w_stream_beat}};
      r_clr       <= {N_LANES{w_stream_beat && (r_cnt == '0)}};
      r_drn       <= (r_state == DRAIN) ? r_drn + W_DRN'(1) : '0;
      if (w_accept) begin
        r_len        <= cmd_len;
        r_cnt        <= '0;
        r_result_cnt <= '0;
        r_dfs        <= {N_PE{cmd_sel}};
      end else begin
        if (w_stream_beat) r_cnt <= r_cnt + W_LEN'(1);
        if ((r_state == STREAM || r_state == DRAIN) && (|arr_result_en) && (r_result_cnt != '1))
          r_result_cnt <= r_result_cnt + W_LEN'(1);
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset || w_accept) r_stall_cnt <= '0;
    else if ((r_state == LOAD_W || r_state == STREAM) && !in_valid) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_count = r_stall_cnt;
`endif

  assign cmd_ready            = r_cmd_ready;
  assign in_ready             = r_in_ready;
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign arr_update_w         = w_update_w;
  assign arr_dataflow_select  = r_dfs;
  assign arr_mac_en           = r_mac_en;
  assign arr_clr_and_plus_one = r_clr;
  assign result_count         = r_result_cnt;

endmodule

// File: tb/tb_j_systolic_scheduler.sv
// Bench for j_systolic_scheduler (4x4 array, 8 drain cycles): directed jobs against a trace model plus literal pins.
module tb_j_systolic_scheduler;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int NMX   = 8;
  localparam int WM    = 3;
  localparam int WL    = 16;
  localparam int D     = 8;
  localparam int LANES = 4 * H;
  localparam int DFS_W = W * H * WM;
  localparam int MAXC  = 64;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WL-1:0]    cmd_len;
  logic [WM-1:0]    cmd_sel;
  logic             cmd_skip_wload;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     arr_update_w;
  logic [DFS_W-1:0] arr_dataflow_select;
  logic [LANES-1:0] arr_mac_en;
  logic [LANES-1:0] arr_clr_and_plus_one;
  logic [LANES-1:0] arr_result_en;
  logic             busy;
  logic             done;
  logic [WL-1:0]    result_count;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]      stall_count;
`endif

  j_systolic_scheduler #(
    .SUBARRAY_WIDTH     (W),
    .SUBARRAY_HEIGHT    (H),
    .NUM_DATAFLOW_PER_MX(NMX),
    .W_DATA_MUX         (WM),
    .W_LEN              (WL),
    .DRAIN_CYCLES       (D)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_len             (cmd_len),
    .cmd_sel             (cmd_sel),
    .cmd_skip_wload      (cmd_skip_wload),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .arr_update_w        (arr_update_w),
    .arr_dataflow_select (arr_dataflow_select),
    .arr_mac_en          (arr_mac_en),
    .arr_clr_and_plus_one(arr_clr_and_plus_one),
    .arr_result_en       (arr_result_en),
    .busy                (busy),
    .done                (done),
    .result_count        (result_count)
`ifdef SCHED_PERF_CNT_EN
    ,
    .stall_count         (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Per-cycle stimulus (cycle 0 = first cycle after the accepting edge) and expected trace.
  bit         vpat[MAXC];
  bit         rpat[MAXC];
  logic [W-1:0] e_upd[MAXC];
  bit         e_mac[MAXC];
  bit         e_clr[MAXC];
  bit         e_inr[MAXC];
  bit         e_cmdr[MAXC];
  bit         e_busy[MAXC];
  bit         e_done[MAXC];
  int         e_rc[MAXC];
  int         e_stall;
  int         n_cyc;
  logic [WM-1:0] m_sel;

  task automatic pat_default();
    for (int i = 0; i < MAXC; i++) begin
      vpat[i] = 1'b1;
      rpat[i] = 1'b0;
    end
  endtask

  // A beat is taken on edge j when in_valid was high during cycle j-1; the first W taken beats
  // are weights (unless skipped), the next len are activations; drain, done and idle follow.
  function automatic void build_model(input int len, input bit skip);
    int edges[$];
    int nw, last, dn, s, cnt;
    nw = skip ? 0 : W;
    for (int j = 1; j < MAXC; j++) if (vpat[j-1]) edges.push_back(j);
    for (int k = 0; k < MAXC; k++) begin
      e_upd[k] = '0; e_mac[k] = 0; e_clr[k] = 0; e_inr[k] = 0;
      e_cmdr[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_rc[k] = 0;
    end
    e_stall = 0;
    if (len == 0) begin
      e_done[0] = 1;
      e_cmdr[1] = 1;
      n_cyc = 2;
      return;
    end
    last  = edges[nw + len - 1];
    dn    = last + D;
    s     = skip ? 0 : edges[W-1];
    n_cyc = dn + 2;
    for (int k = 0; k < n_cyc; k++) begin
      e_busy[k] = (k < dn);
      e_done[k] = (k == dn);
      e_cmdr[k] = (k > dn);
      e_inr[k]  = (k < last);
      if (k < last && !vpat[k]) e_stall++;
    end
    for (int i = 0; i < nw; i++) e_upd[edges[i]] = W'(1 << i);
    for (int i = 0; i < len; i++) e_mac[edges[nw + i]] = 1;
    e_clr[edges[nw]] = 1;
    cnt = 0;
    for (int k = 0; k < n_cyc; k++) begin
      e_rc[k] = cnt;
      if (k >= s && k < dn && rpat[k]) cnt++;
    end
  endfunction

  bit tr_on = 0;
  int tr_k, done_k, upd_cnt, mac_cnt, clr_cnt, rc_at_done;

  always @(negedge clk) begin : cmp
    string t;
    if (tr_on && tr_k < n_cyc) begin
      t = $sformatf("@%0d", tr_k);
      check({"update_w", t}, 64'(arr_update_w), 64'(e_upd[tr_k]));
      check({"mac_en", t}, 64'(arr_mac_en), 64'({LANES{e_mac[tr_k]}}));
      check({"clr", t}, 64'(arr_clr_and_plus_one), 64'({LANES{e_clr[tr_k]}}));
      check({"in_ready", t}, 64'(in_ready), 64'(e_inr[tr_k]));
      check({"cmd_ready", t}, 64'(cmd_ready), 64'(e_cmdr[tr_k]));
      check({"busy", t}, 64'(busy), 64'(e_busy[tr_k]));
      check({"done", t}, 64'(done), 64'(e_done[tr_k]));
      check({"result_count", t}, 64'(result_count), 64'(e_rc[tr_k]));
      check({"dataflow_sel", t}, 64'(arr_dataflow_select), 64'({(W*H){m_sel}}));
`ifdef SCHED_PERF_CNT_EN
      if (e_done[tr_k]) check({"stall_count", t}, 64'(stall_count), 64'(e_stall));
`endif
      if (arr_update_w != '0) upd_cnt++;
      if (|arr_mac_en) mac_cnt++;
      if (|arr_clr_and_plus_one) clr_cnt++;
      if (done) begin
        done_k     = tr_k;
        rc_at_done = int'(result_count);
      end
      tr_k++;
    end
  end

  // Set vpat/rpat before calling. Stimulus changes 2 time units after each rising edge.
  task automatic run_job(input int len, input logic [WM-1:0] sel, input bit skip);
    int guard;
    build_model(len, skip);
    m_sel = sel;
    guard = 0;
    @(posedge clk); #2;
    while (!cmd_ready && guard < 200) begin
      @(posedge clk); #2;
      guard++;
    end
    check("wait_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_len = WL'(len); cmd_sel = sel; cmd_skip_wload = skip; in_valid = 1'b0;
    @(posedge clk); #2;
    cmd_valid = 1'b0; cmd_len = '0; cmd_skip_wload = 1'b0;
    tr_k = 0; done_k = -1; upd_cnt = 0; mac_cnt = 0; clr_cnt = 0; rc_at_done = -1;
    tr_on = 1'b1;
    for (int k = 0; k < n_cyc; k++) begin
      in_valid      = vpat[k];
      arr_result_en = rpat[k] ? LANES'(16'h0100) : '0;
      // A descriptor offered while busy must be ignored.
      if (k == 1 && len > 0) begin
        cmd_valid = 1'b1; cmd_len = WL'(7);
      end else begin
        cmd_valid = 1'b0; cmd_len = '0;
      end
      @(posedge clk); #2;
    end
    tr_on = 1'b0; in_valid = 1'b0; arr_result_en = '0; cmd_valid = 1'b0; cmd_len = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int seen_done;
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_sel = '0; cmd_skip_wload = 1'b0;
    in_valid = 1'b0; arr_result_en = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_update_w", 64'(arr_update_w), 64'd0);
    check("rst_mac_en", 64'(arr_mac_en), 64'd0);
    check("rst_dfs", 64'(arr_dataflow_select), 64'd0);
    check("rst_result_count", 64'(result_count), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Basic job: 4 weight columns, 3 beats, 8 drain cycles.
    pat_default();
    run_job(3, 3'd2, 1'b0);
    check("basic_done_cycle", 64'(done_k), 64'd15);
    check("basic_col0", 64'(e_upd[1]), 64'h1);
    check("basic_col3", 64'(e_upd[4]), 64'h8);
    check("basic_mac_cycles", 64'(mac_cnt), 64'd3);
    check("basic_clr_cycles", 64'(clr_cnt), 64'd1);

    // Skip weight load.
    pat_default();
    run_job(2, 3'd5, 1'b1);
    check("skip_done_cycle", 64'(done_k), 64'd10);
    check("skip_update_cycles", 64'(upd_cnt), 64'd0);

    // Bubbles while streaming: in_valid 1,0,0,1,1,1.
    pat_default();
    vpat[1] = 1'b0; vpat[2] = 1'b0;
    run_job(4, 3'd1, 1'b1);
    check("bubble_done_cycle", 64'(done_k), 64'd14);
    check("bubble_mac_cycles", 64'(mac_cnt), 64'd4);
    check("bubble_clr_cycles", 64'(clr_cnt), 64'd1);
`ifdef SCHED_PERF_CNT_EN
    check("bubble_stall_lit", 64'(stall_count), 64'd2);
`endif

    // Zero length goes straight to DONE.
    pat_default();
    run_job(0, 3'd6, 1'b0);
    check("zero_done_cycle", 64'(done_k), 64'd0);
    check("zero_mac_cycles", 64'(mac_cnt), 64'd0);
    check("zero_update_cycles", 64'(upd_cnt), 64'd0);

    // Reset after the first of five streamed beats.
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_len = WL'(5); cmd_sel = 3'd3; cmd_skip_wload = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0; cmd_skip_wload = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #3;
    check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_mac_en", 64'(arr_mac_en), 64'd0);
    check("abort_clr", 64'(arr_clr_and_plus_one), 64'd0);
    check("abort_dfs", 64'(arr_dataflow_select), 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    pat_default();
    run_job(1, 3'd4, 1'b0);
    check("post_abort_done_cycle", 64'(done_k), 64'd13);

    // Result counting: one weight-phase bubble, five result cycles in DRAIN, strays outside.
    pat_default();
    vpat[1] = 1'b0;
    rpat[2] = 1'b1;
    rpat[8] = 1'b1; rpat[9] = 1'b1; rpat[11] = 1'b1; rpat[13] = 1'b1; rpat[14] = 1'b1;
    rpat[16] = 1'b1;
    run_job(2, 3'd7, 1'b0);
    check("rc_at_done", 64'(rc_at_done), 64'd5);
`ifdef SCHED_PERF_CNT_EN
    check("rc_job_stall_lit", 64'(stall_count), 64'd1);
`endif
    repeat (2) @(negedge clk);
    check("rc_held_idle", 64'(result_count), 64'd5);
    pat_default();
    run_job(1, 3'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
